exec_stage_pipe: RTL and testbench

//  Pipelined Y86-64 execute stage: one-deep output register between decode and memory, with valid/ready handshake.

---
 rtl/y86_pkg.sv | 34 +++
 rtl/y86_alu.sv | 22 ++
 rtl/exec_stage_pipe.sv | 107 ++++++++++
 tb/tb_exec_stage_pipe.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 encodings, ALU ops, condition codes and status values
package y86_pkg;
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_CMOVXX = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] RNONE_ID = 4'hF;
  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_XOR} alu_op_e;
  typedef enum logic [3:0] {C_ALWAYS, C_LE, C_L, C_E, C_NE, C_GE, C_G} cond_e;
  typedef enum logic [2:0] {S_AOK = 3'd1, S_HLT = 3'd2, S_ADR = 3'd3, S_INS = 3'd4} stat_e;
  // cc is {zf,sf,of}; unknown condition codes evaluate false
  function automatic logic cond_eval(input logic [3:0] fn, input logic [2:0] cc);
    logic lt;
    lt = cc[1] ^ cc[0];
    case (fn)
      C_ALWAYS: return 1'b1;
      C_LE:     return lt | cc[2];
      C_L:      return lt;
      C_E:      return cc[2];
      C_NE:     return !cc[2];
      C_GE:     return !lt;
      C_G:      return !lt && !cc[2];
      default:  return 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/y86_alu.sv
// y86_alu: combinational Y86 ALU computing b op a with zero/sign/overflow flags
module y86_alu import y86_pkg::*; #(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_op_e           op,
  output logic [DATA_W-1:0] res,
  output logic              zf,
  output logic              sf,
  output logic              of
);
  localparam int M = DATA_W - 1;
  // result and flags; sub is b-a so overflow is judged against b's sign
  always_comb begin
    res = op == ALU_ADD ? b + a : op == ALU_SUB ? b - a : op == ALU_AND ? b & a : b ^ a;
    zf = res == '0;
    sf = res[M];
    of = op == ALU_ADD ? (a[M] == b[M]) && (res[M] != a[M]) :
         op == ALU_SUB ? (a[M] != b[M]) && (res[M] != b[M]) : 1'b0;
  end
endmodule

// File: rtl/exec_stage_pipe.sv
// exec_stage_pipe: pipelined Y86-64 execute stage with CC register and valid/ready output register
module exec_stage_pipe import y86_pkg::*; #(
  parameter int              DATA_W     = 64,
  parameter int              REG_W      = 4,
  parameter logic [REG_W-1:0] RNONE     = RNONE_ID,
  parameter int              STACK_STEP = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              cc_block,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        icode,
  input  logic [3:0]        ifun,
  input  logic [DATA_W-1:0] valA,
  input  logic [DATA_W-1:0] valB,
  input  logic [DATA_W-1:0] valC,
  input  logic [REG_W-1:0]  dstE,
  input  logic [REG_W-1:0]  dstM,
  input  logic [2:0]        stat_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_icode,
  output logic [DATA_W-1:0] out_valE,
  output logic [DATA_W-1:0] out_valA,
  output logic [REG_W-1:0]  out_dstE,
  output logic [REG_W-1:0]  out_dstM,
  output logic              out_cnd,
  output logic [2:0]        out_stat,
  output logic [2:0]        cc_out
);
  logic [DATA_W-1:0] alu_a, alu_b, res;
  alu_op_e           op;
  logic              zf, sf, of, is_op, is_cc, illegal, cnd, acc, cc_wr;
  logic [2:0]        stat_nx, cc;
  assign in_ready = !out_valid || out_ready;
  assign acc      = in_valid && in_ready;
  assign cc_out   = cc;
  // operand selection per instruction class; stack ops step by STACK_STEP
  always_comb begin
    alu_a = '0;
    alu_b = '0;
    op    = ALU_ADD;
    case (icode)
      I_OPQ: begin
        alu_a = valA;
        alu_b = valB;
        op    = alu_op_e'(ifun[1:0]);
      end
      I_IRMOVQ: alu_a = valC;
      I_RMMOVQ, I_MRMOVQ: begin
        alu_a = valC;
        alu_b = valB;
      end
      I_CMOVXX: alu_a = valA;
      I_CALL, I_PUSHQ: begin
        alu_a = DATA_W'(STACK_STEP);
        alu_b = valB;
        op    = ALU_SUB;
      end
      I_RET, I_POPQ: begin
        alu_a = DATA_W'(STACK_STEP);
        alu_b = valB;
      end
      default: ;
    endcase
  end
  y86_alu #(.DATA_W(DATA_W)) u_alu (.a(alu_a), .b(alu_b), .op(op), .res(res), .zf(zf), .sf(sf), .of(of));
  // legality, condition outcome from the pre-update CC, and CC write gating
  always_comb begin
    is_op   = icode == I_OPQ;
    is_cc   = icode == I_CMOVXX || icode == I_JXX;
    illegal = (is_op && ifun > 4'd3) || (is_cc && ifun > 4'd6);
    cnd     = is_cc && !illegal && cond_eval(ifun, cc);
    stat_nx = stat_in != S_AOK ? stat_in : illegal ? S_INS : S_AOK;
    cc_wr   = acc && is_op && !illegal && stat_in == S_AOK && !cc_block && !flush;
  end
  // output register and CC; flush wins over accept and discards its CC write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_icode <= I_HALT;
      out_valE  <= '0;
      out_valA  <= '0;
      out_dstE  <= RNONE;
      out_dstM  <= RNONE;
      out_cnd   <= 1'b0;
      out_stat  <= S_AOK;
      cc        <= 3'b100;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (acc) begin
      out_valid <= 1'b1;
      out_icode <= icode;
      out_valE  <= res;
      out_valA  <= valA;
      out_dstE  <= icode == I_CMOVXX && !cnd ? RNONE : dstE;
      out_dstM  <= dstM;
      out_cnd   <= cnd;
      out_stat  <= stat_nx;
      if (cc_wr) cc <= {zf, sf, of};
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_exec_stage_pipe.sv
// tb_exec_stage_pipe: directed bench with a behavioural execute-stage model checked every cycle
module tb_exec_stage_pipe;
  logic        clk = 0, rst, flush, cc_block, in_valid, in_ready, out_valid, out_ready, out_cnd;
  logic [3:0]  icode, ifun, out_icode, dstE, dstM, out_dstE, out_dstM;
  logic [63:0] valA, valB, valC, out_valE, out_valA;
  logic [2:0]  stat_in, out_stat, cc_out;
  int          nerr = 0, nchk = 0;

  exec_stage_pipe dut (
    .clk(clk), .rst(rst), .flush(flush), .cc_block(cc_block), .in_valid(in_valid), .in_ready(in_ready),
    .icode(icode), .ifun(ifun), .valA(valA), .valB(valB), .valC(valC), .dstE(dstE), .dstM(dstM),
    .stat_in(stat_in), .out_valid(out_valid), .out_ready(out_ready), .out_icode(out_icode),
    .out_valE(out_valE), .out_valA(out_valA), .out_dstE(out_dstE), .out_dstM(out_dstM),
    .out_cnd(out_cnd), .out_stat(out_stat), .cc_out(cc_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // behavioural model state
  logic        m_valid, m_cnd, m_zf, m_sf, m_of, m_vchk, bad, cond, nof;
  logic [3:0]  m_icode, m_dste, m_dstm;
  logic [63:0] m_vale, m_vala;
  logic [2:0]  m_stat;
  logic [64:0] wide;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid = 0; m_icode = 0; m_vale = 0; m_vala = 0; m_dste = 4'hF; m_dstm = 4'hF;
      m_cnd = 0; m_stat = 1; m_zf = 1; m_sf = 0; m_of = 0; m_vchk = 1;
    end else if (flush) begin
      m_valid = 0;
    end else if (in_valid && (!m_valid || out_ready)) begin
      bad = (icode == 6 && ifun > 3) || ((icode == 2 || icode == 7) && ifun > 6);
      case (ifun)
        0: cond = 1;
        1: cond = (m_sf != m_of) || m_zf;
        2: cond = m_sf != m_of;
        3: cond = m_zf;
        4: cond = !m_zf;
        5: cond = m_sf == m_of;
        6: cond = m_sf == m_of && !m_zf;
        default: cond = 0;
      endcase
      m_cnd = (icode == 2 || icode == 7) && !bad && cond;
      m_vchk = 1; nof = 0;
      case (icode)
        6: case (ifun)
             0: begin m_vale = valB + valA; wide = {valB[63], valB} + {valA[63], valA}; nof = wide[64] ^ wide[63]; end
             1: begin m_vale = valB - valA; wide = {valB[63], valB} - {valA[63], valA}; nof = wide[64] ^ wide[63]; end
             2: m_vale = valB & valA;
             3: m_vale = valB ^ valA;
             default: m_vchk = 0;
           endcase
        2: m_vale = valA;
        3: m_vale = valC;
        4, 5: m_vale = valC + valB;
        8, 10: m_vale = valB - 8;
        9, 11: m_vale = valB + 8;
        default: m_vchk = 0;
      endcase
      if (icode == 6 && !bad && stat_in == 1 && !cc_block) begin
        m_zf = m_vale == 0; m_sf = m_vale[63]; m_of = nof;
      end
      m_valid = 1; m_icode = icode; m_vala = valA; m_dstm = dstM;
      m_dste = (icode == 2 && !m_cnd) ? 4'hF : dstE;
      m_stat = stat_in != 1 ? stat_in : bad ? 3'd4 : 3'd1;
    end else if (out_ready) begin
      m_valid = 0;
    end
  end

  // compare DUT against the model on every falling edge
  always @(negedge clk) begin
    chk("out_valid", out_valid, m_valid);
    chk("in_ready", in_ready, !m_valid || out_ready);
    chk("cc_out", cc_out, {m_zf, m_sf, m_of});
    if (m_valid) begin
      chk("out_icode", out_icode, m_icode);
      if (m_vchk) chk("out_valE", out_valE, m_vale);
      chk("out_valA", out_valA, m_vala);
      chk("out_dstE", out_dstE, m_dste);
      chk("out_dstM", out_dstM, m_dstm);
      chk("out_cnd", out_cnd, m_cnd);
      chk("out_stat", out_stat, m_stat);
    end
  end

  task automatic send(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] a, input logic [63:0] b,
                      input logic [63:0] c, input logic [3:0] de, input logic [3:0] dm, input logic [2:0] st);
    logic got;
    @(negedge clk); #1;
    icode = ic; ifun = fn; valA = a; valB = b; valC = c; dstE = de; dstM = dm; stat_in = st; in_valid = 1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      got = in_ready;
      @(posedge clk);
      if (!got) #1;
    end
    chk("accept", got, 1);
    #1 in_valid = 0;
  endtask

  initial begin
    rst = 1; flush = 0; cc_block = 0; in_valid = 0; out_ready = 1;
    icode = 0; ifun = 0; valA = 0; valB = 0; valC = 0; dstE = 4'hF; dstM = 4'hF; stat_in = 1;
    repeat (2) @(negedge clk);
    chk("reset_stat", out_stat, 1);
    chk("reset_dstM", out_dstM, 4'hF);
    #1 rst = 0;
    // add overflow
    send(6, 0, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 0, 2, 4'hF, 1);
    @(negedge clk);
    chk("add_valE", out_valE, 64'h8000_0000_0000_0000);
    chk("add_cc", cc_out, 3'b011);
    send(7, 2, 0, 0, 0, 4'hF, 4'hF, 1);
    @(negedge clk);
    chk("jl_cnd", out_cnd, 0);
    send(7, 4, 0, 0, 0, 4'hF, 4'hF, 1);
    @(negedge clk);
    chk("jne_cnd", out_cnd, 1);
    // asynchronous reset while an instruction is held
    #2 rst = 1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_cc", cc_out, 3'b100);
    chk("arst_dstE", out_dstE, 4'hF);
    @(negedge clk); #1 rst = 0;
    // sub to zero then not-taken cmovne
    send(6, 1, 5, 5, 0, 1, 4'hF, 1);
    @(negedge clk);
    chk("sub_valE", out_valE, 0);
    chk("sub_cc", cc_out, 3'b100);
    send(2, 4, 64'h1234, 0, 0, 3, 4'hF, 1);
    @(negedge clk);
    chk("cmovne_cnd", out_cnd, 0);
    chk("cmovne_dstE", out_dstE, 4'hF);
    // gated CC writes
    cc_block = 1;
    send(6, 1, 5, 3, 0, 1, 4'hF, 1);
    cc_block = 0;
    @(negedge clk);
    chk("ccblk_cc", cc_out, 3'b100);
    chk("ccblk_stat", out_stat, 1);
    send(6, 1, 5, 3, 0, 1, 4'hF, 2);
    @(negedge clk);
    chk("hlt_cc", cc_out, 3'b100);
    chk("hlt_stat", out_stat, 2);
    // back-pressure
    send(3, 0, 0, 0, 64'h55, 4, 4'hF, 1);
    out_ready = 0;
    icode = 3; ifun = 0; valC = 64'h66; dstE = 5; stat_in = 1; in_valid = 1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_valE", out_valE, 64'h55);
      chk("stall_dstE", out_dstE, 4);
    end
    #1 out_ready = 1;
    @(posedge clk); #1 in_valid = 0;
    @(negedge clk);
    chk("unstall_valE", out_valE, 64'h66);
    // flush with accepted OPq
    send(3, 0, 0, 0, 64'h77, 6, 4'hF, 1);
    @(negedge clk); #1;
    icode = 6; ifun = 1; valA = 5; valB = 3; stat_in = 1; in_valid = 1; flush = 1;
    @(posedge clk); #1 in_valid = 0; flush = 0;
    @(negedge clk);
    chk("flush_valid", out_valid, 0);
    chk("flush_cc", cc_out, 3'b100);
    send(6, 7, 5, 3, 0, 1, 4'hF, 1);
    @(negedge clk);
    chk("ins_stat", out_stat, 4);
    chk("ins_cc", cc_out, 3'b100);
    // remaining instruction classes
    send(6, 1, 5, 3, 0, 1, 4'hF, 1);
    @(negedge clk);
    chk("neg_cc", cc_out, 3'b010);
    send(2, 2, 64'hABC, 0, 0, 7, 4'hF, 1);
    @(negedge clk);
    chk("cmovl_dstE", out_dstE, 7);
    send(6, 2, 64'hF0, 64'h3C, 0, 1, 4'hF, 1);
    send(6, 3, 64'hFF, 64'hFF, 0, 1, 4'hF, 1);
    send(4, 0, 64'h9, 64'h100, 64'h20, 4'hF, 4'hF, 1);
    send(5, 0, 0, 64'h100, 64'h18, 4'hF, 3, 1);
    send(8, 0, 0, 64'h200, 64'h400, 4, 4'hF, 1);
    @(negedge clk);
    chk("call_valE", out_valE, 64'h1F8);
    send(9, 0, 64'h1F8, 64'h1F8, 0, 4, 4'hF, 1);
    send(10, 0, 64'h5, 64'h100, 0, 4, 4'hF, 1);
    send(11, 0, 64'h100, 64'h100, 0, 4, 2, 1);
    @(negedge clk);
    chk("pop_valE", out_valE, 64'h108);
    send(7, 0, 0, 0, 64'h40, 4'hF, 4'hF, 3);
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
